wr_ptr_ctrl: RTL and testbench
==============================

WR_PTR_CTRL -- requirements
Module: wr_ptr_ctrl

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 4, meaning FIFO depth is 2^ADDR_W entries.
REQ-002 The block SHALL take parameter AFULL_THRESH, default 2^ADDR_W-2, the level at which the almost-full flag asserts.
REQ-003 The block SHALL have port i_clk, input, 1 bit: write-domain clock; all state updates on its rising edge.
REQ-004 The block SHALL have port i_arst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port i_wValid, input, 1 bit: write request from the producer.
REQ-006 The block SHALL have port o_wReady, output, 1 bit: high means the block accepts a write this cycle.
REQ-007 The block SHALL have port i_rSyncPtr, input, ADDR_W+1 bits: Gray-coded read pointer, already two-flop synchronized into i_clk.
REQ-008 The block SHALL have port o_wPtr, output, ADDR_W+1 bits: registered Gray-coded write pointer, sent to the read domain.
REQ-009 The block SHALL have port o_memWe, output, 1 bit: write enable to the dual-port storage.
REQ-010 The block SHALL have port o_memAddr, output, ADDR_W bits: storage write address.
REQ-011 The block SHALL have port o_full, output, 1 bit: registered full flag.
REQ-012 The block SHALL have port o_almostFull, output, 1 bit: registered almost-full flag.
REQ-013 The block SHALL have port o_level, output, ADDR_W+1 bits: registered fill level, 0..2^ADDR_W.
REQ-014 The block SHALL have port o_overflow, output, 1 bit: sticky write-when-full error.
REQ-015 The block SHALL have port i_clrOverflow, input, 1 bit: clears o_overflow.

Function
REQ-016 The block SHALL hold a binary write counter wBin, ADDR_W+1 bits, that wraps modulo 2^(ADDR_W+1).
REQ-017 The block SHALL drive o_wReady = !o_full, combinationally.
REQ-018 An accept SHALL occur when i_wValid && !o_full; on an accept, wBin increments by 1 at the next edge.
REQ-019 The block SHALL drive o_memWe = accept and o_memAddr = wBin[ADDR_W-1:0], both combinational, so data is written to the current address in the accept cycle.
REQ-020 On a write attempt while o_full=1, the block SHALL keep wBin and o_wPtr unchanged and hold o_memWe at 0.
REQ-021 The block SHALL register o_wPtr = wBinNext ^ (wBinNext >> 1) on the same edge as wBin, so it is always the Gray code of wBin and changes by at most one bit per cycle.
REQ-022 The block SHALL register o_full = (gray(wBinNext) == {~i_rSyncPtr[ADDR_W:ADDR_W-1], i_rSyncPtr[ADDR_W-2:0]}).
REQ-023 As a result, full SHALL assert on the edge that accepts the last free slot, and SHALL deassert one edge after i_rSyncPtr advances.
REQ-024 The block SHALL convert i_rSyncPtr to a binary rBin, combinationally (prefix-XOR from the MSB).
REQ-025 The block SHALL register o_level = (wBinNext - rBin) mod 2^(ADDR_W+1).
REQ-026 The level SHALL be pessimistic because of synchronizer delay: it never under-reports occupancy.
REQ-027 The block SHALL register o_almostFull = (levelNext >= AFULL_THRESH).
REQ-028 o_overflow SHALL set on the edge after any cycle with i_wValid && o_full.
REQ-029 o_overflow SHALL clear on the edge after i_clrOverflow.
REQ-030 When set and clear occur in the same cycle, set SHALL win.
REQ-031 A simultaneous accept and i_rSyncPtr change SHALL both be reflected in the next o_level and o_full.
REQ-032 The block SHALL contain no combinational path from i_rSyncPtr to any output.

Reset
REQ-033 While i_arst=1, wBin, o_wPtr, o_level, o_full, o_almostFull and o_overflow SHALL be 0 immediately, independent of i_clk.
REQ-034 During reset, o_wReady SHALL be 1 and o_memWe SHALL equal i_wValid & o_wReady, with writes to address 0 having no lasting effect.
REQ-035 A reset asserted mid-operation SHALL discard all pointer state.
REQ-036 After reset the read domain SHALL also be reset; the block does not reconcile pointers itself.

Verification (ADDR_W=4, AFULL_THRESH=14)
REQ-037 Reset -> o_wPtr=0, o_level=0, o_full=0, o_almostFull=0, o_overflow=0, o_wReady=1.
REQ-038 16 back-to-back writes, i_rSyncPtr=0 -> o_memAddr steps 0..15; o_almostFull=1 after the 14th edge; o_full=1, o_level=16 and o_wPtr=5'b11000 after the 16th edge; no 17th o_memWe.
REQ-039 While full, i_wValid=1 for 3 cycles -> o_wPtr holds, o_overflow=1; i_clrOverflow with i_wValid=0 -> 0 next edge; i_clrOverflow and full write together -> stays 1.
REQ-040 From full, i_rSyncPtr=5'b00001 -> o_full=0 and o_level=15 one edge later, o_almostFull stays 1.
REQ-041 40 writes with i_rSyncPtr tracking 2 behind -> wBin wraps 31->0, o_wPtr changes exactly one bit per accept, o_full never asserts, o_level=2.
REQ-042 i_arst pulse mid-burst between clock edges -> all registered outputs 0 immediately; writes resume at o_memAddr=0.

Source files
------------

// File: rtl/wr_ptr_ctrl_if.sv
// Write-side handshake and storage write port of the FIFO write-pointer controller.
interface wr_ptr_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              i_wValid;
    logic              o_wReady;
    logic              o_memWe;
    logic [ADDR_W-1:0] o_memAddr;

    // Producer side: raises the request, sees ready and the storage write strobe.
    modport master (
        output i_wValid,
        input  o_wReady,
        input  o_memWe,
        input  o_memAddr
    );

    // Controller side.
    modport slave (
        input  i_wValid,
        output o_wReady,
        output o_memWe,
        output o_memAddr
    );
endinterface

// File: rtl/wr_ptr_ctrl.sv
// Write-domain pointer controller of an asynchronous FIFO.
// Keeps a binary write counter plus its registered Gray copy for the read domain,
// and derives full / almost-full / level from the synchronized Gray read pointer.
// Level and full are pessimistic: the read pointer arrives late, never early.
module wr_ptr_ctrl #(
    parameter int ADDR_W       = 4,
    parameter int AFULL_THRESH = (2 ** ADDR_W) - 2
) (
    input  logic              i_clk,
    input  logic              i_arst,
    wr_ptr_ctrl_if.slave      wif,
    input  logic [ADDR_W:0]   i_rSyncPtr,
    output logic [ADDR_W:0]   o_wPtr,
    output logic              o_full,
    output logic              o_almostFull,
    output logic [ADDR_W:0]   o_level,
    output logic              o_overflow,
    input  logic              i_clrOverflow
);

    localparam logic [ADDR_W:0] AFULL_LVL = (ADDR_W + 1)'(AFULL_THRESH);

    logic [ADDR_W:0] wBin;
    logic [ADDR_W:0] wBinNext;
    logic [ADDR_W:0] wGrayNext;
    logic [ADDR_W:0] rBin;
    logic [ADDR_W:0] rGrayFull;
    logic [ADDR_W:0] levelNext;
    logic            fullNext;
    logic            almostFullNext;
    logic            accept;

    // Handshake and storage write port; ready depends only on the registered full flag.
    always_comb begin
        accept         = wif.i_wValid && !o_full;
        wif.o_wReady   = !o_full;
        wif.o_memWe    = accept;
        wif.o_memAddr  = wBin[ADDR_W-1:0];
    end

    // Gray read pointer to binary: each bit is the XOR of itself and all bits above it.
    always_comb begin
        rBin = '0;
        for (int i = 0; i <= ADDR_W; i++) begin
            rBin[i] = ^(i_rSyncPtr >> i);
        end
    end

    // Next-state pointer arithmetic and flag evaluation.
    always_comb begin
        wBinNext       = wBin + {{ADDR_W{1'b0}}, accept};
        wGrayNext      = wBinNext ^ (wBinNext >> 1);
        // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
        rGrayFull      = {~i_rSyncPtr[ADDR_W:ADDR_W-1], i_rSyncPtr[ADDR_W-2:0]};
        fullNext       = (wGrayNext == rGrayFull);
        levelNext      = wBinNext - rBin;
        almostFullNext = (levelNext >= AFULL_LVL);
    end

    // Pointer and status registers; reset discards all pointer state.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            wBin         <= '0;
            o_wPtr       <= '0;
            o_level      <= '0;
            o_full       <= 1'b0;
            o_almostFull <= 1'b0;
        end else begin
            wBin         <= wBinNext;
            o_wPtr       <= wGrayNext;
            o_level      <= levelNext;
            o_full       <= fullNext;
            o_almostFull <= almostFullNext;
        end
    end

    // Sticky write-while-full error; a new offence beats a clear in the same cycle.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            o_overflow <= 1'b0;
        end else if (wif.i_wValid && o_full) begin
            o_overflow <= 1'b1;
        end else if (i_clrOverflow) begin
            o_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wr_ptr_ctrl.sv
// Directed bench for wr_ptr_ctrl (ADDR_W=4, AFULL_THRESH=14) with a queue scoreboard.
module tb_wr_ptr_ctrl;

    typedef struct {
        logic [4:0] wptr;
        logic [4:0] level;
        logic       full;
        logic       af;
        logic       ovf;
    } exp_t;

    logic       i_clk;
    logic       i_arst;
    logic [4:0] i_rSyncPtr;
    logic [4:0] o_wPtr;
    logic       o_full;
    logic       o_almostFull;
    logic [4:0] o_level;
    logic       o_overflow;
    logic       i_clrOverflow;

    wr_ptr_ctrl_if #(.ADDR_W(4)) wif ();

    wr_ptr_ctrl #(.ADDR_W(4), .AFULL_THRESH(14)) dut (
        .i_clk         (i_clk),
        .i_arst        (i_arst),
        .wif           (wif),
        .i_rSyncPtr    (i_rSyncPtr),
        .o_wPtr        (o_wPtr),
        .o_full        (o_full),
        .o_almostFull  (o_almostFull),
        .o_level       (o_level),
        .o_overflow    (o_overflow),
        .i_clrOverflow (i_clrOverflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    // Reference model state: write count, registered full, sticky overflow.
    logic [4:0] m_w;
    logic       m_full;
    logic       m_ovf;

    function automatic logic [4:0] gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_w    = '0;
        m_full = 1'b0;
        m_ovf  = 1'b0;
        sb.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wptr"},  o_wPtr,       5'd0);
        check({tag, "_level"}, o_level,      5'd0);
        check({tag, "_full"},  o_full,       1'b0);
        check({tag, "_af"},    o_almostFull, 1'b0);
        check({tag, "_ovf"},   o_overflow,   1'b0);
        check({tag, "_rdy"},   wif.o_wReady, 1'b1);
    endtask

    // One clock of stimulus: drive, check combinational outputs, push expectation,
    // then pop and compare the registered outputs after the edge.
    task automatic step(input logic v, input logic clr, input logic [4:0] rb);
        logic       acc;
        logic       ovf_n;
        logic [4:0] lvl;
        logic [4:0] prev_wptr;
        exp_t       e;
        @(negedge i_clk);
        wif.i_wValid  = v;
        i_clrOverflow = clr;
        i_rSyncPtr    = gray(rb);
        #1;
        acc = v && !m_full;
        check("wready", wif.o_wReady, !m_full);
        check("memwe",  wif.o_memWe,  acc);
        if (acc) check("memaddr", wif.o_memAddr, m_w[3:0]);
        ovf_n  = (v && m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_ovf  = ovf_n;
        m_w    = m_w + 5'(acc);
        lvl    = m_w - rb;
        m_full = (lvl == 5'd16);
        e = '{wptr: gray(m_w), level: lvl, full: m_full, af: (lvl >= 5'd14), ovf: m_ovf};
        sb.push_back(e);
        prev_wptr = o_wPtr;
        @(posedge i_clk);
        #1;
        e = sb.pop_front();
        check("wptr",     o_wPtr,       e.wptr);
        check("level",    o_level,      e.level);
        check("full",     o_full,       e.full);
        check("afull",    o_almostFull, e.af);
        check("overflow", o_overflow,   e.ovf);
        check("wptr_bits", $countones(o_wPtr ^ prev_wptr), acc ? 1 : 0);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        wif.i_wValid  = 1'b0;
        i_clrOverflow = 1'b0;
        i_rSyncPtr    = '0;
        i_arst        = 1'b1;
        @(posedge i_clk);
        #1;
        check_reset_outputs("rst");
        @(negedge i_clk);
        i_arst = 1'b0;
        model_reset();
    endtask

    initial begin
        wif.i_wValid  = 1'b0;
        i_clrOverflow = 1'b0;
        i_rSyncPtr    = '0;
        i_arst        = 1'b0;
        model_reset();

        // Reset state observed before any clock edge.
        #1 i_arst = 1'b1;
        #2;
        check_reset_outputs("por");
        check("por_memwe", wif.o_memWe, 1'b0);
        @(negedge i_clk);
        i_arst = 1'b0;

        // Fill: 16 back-to-back writes with the read pointer parked at 0.
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 1'b0, 5'd0);
            if (k == 13) check("afull_at14", o_almostFull, 1'b1);
        end
        check("fill_full",  o_full,  1'b1);
        check("fill_level", o_level, 5'd16);
        check("fill_wptr",  o_wPtr,  5'b11000);

        // Writes while full: pointer holds, no strobe, overflow sets.
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 5'd0);
        check("ovf_set", o_overflow, 1'b1);
        step(1'b0, 1'b1, 5'd0);
        check("ovf_clr", o_overflow, 1'b0);
        step(1'b1, 1'b0, 5'd0);
        step(1'b1, 1'b1, 5'd0);
        check("ovf_set_wins", o_overflow, 1'b1);
        step(1'b0, 1'b1, 5'd0);

        // Read pointer advances by one: full drops, level 15, almost-full stays.
        step(1'b0, 1'b0, 5'd1);
        check("drain_full",  o_full,       1'b0);
        check("drain_level", o_level,      5'd15);
        check("drain_af",    o_almostFull, 1'b1);

        // 40 writes with the reader trailing by two; counter wraps past 31.
        do_reset();
        for (int k = 0; k < 40; k++) begin
            step(1'b1, 1'b0, (k >= 1) ? 5'(k - 1) : 5'd0);
        end
        check("trail_level", o_level, 5'd2);
        check("trail_wptr",  o_wPtr,  gray(5'd8));

        // Asynchronous reset in the middle of a burst.
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 5'd0);
        @(negedge i_clk);
        wif.i_wValid = 1'b1;
        #2 i_arst = 1'b1;
        #1;
        check_reset_outputs("async");
        check("async_memwe",   wif.o_memWe,   1'b1);
        check("async_memaddr", wif.o_memAddr, 4'd0);
        @(posedge i_clk);
        #1;
        check_reset_outputs("async_hold");
        @(negedge i_clk);
        i_arst       = 1'b0;
        wif.i_wValid = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 5'd0);
        check("resume_level", o_level, 5'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
